// File: rtl/seq_pkg.sv
// Shared definitions for the "101" serial link: transmitter state encoding and marker constants.
// The PAR state exists only when SEQ_FRAME_TX_PARITY_EN is defined.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        DATA,
`ifdef SEQ_FRAME_TX_PARITY_EN
        PAR,
`endif
        GAP
    } seq_tx_state_t;

    localparam logic [2:0]  SEQ_MARKER     = 3'b101;
    localparam int unsigned SEQ_MARKER_LEN = 3;

endpackage

// File: rtl/seq_tx_shifter.sv
// MSB-first parallel-load shift register feeding the frame transmitter.
// Running parity output exists only when SEQ_FRAME_TX_PARITY_EN is defined.
module seq_tx_shifter
    import seq_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic              msb
`ifdef SEQ_FRAME_TX_PARITY_EN
    ,
    output logic              parity
`endif
);

    logic [DATA_W-1:0] sreg_q, sreg_d;

    always_comb begin
        sreg_d = sreg_q;
        if (load) begin
            sreg_d = din;
        end else if (shift) begin
            sreg_d = sreg_q << 1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign msb = sreg_q[DATA_W-1];

`ifdef SEQ_FRAME_TX_PARITY_EN
    // XOR of every bit shifted out since the last load.
    logic par_q, par_d;

    always_comb begin
        par_d = par_q;
        if (load) begin
            par_d = 1'b0;
        end else if (shift) begin
            par_d = par_q ^ sreg_q[DATA_W-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign parity = par_q;
`endif

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: "101" marker, payload MSB-first, optional even parity, idle-low gap.
// Define SEQ_FRAME_TX_PARITY_EN to compile in the parity bit.
module seq_frame_tx
    import seq_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              x,
    output logic              x_valid,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned BW = $clog2(DATA_W + 1);

    seq_tx_state_t state_q, state_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [3:0]    gap_cnt_q, gap_cnt_d;
    logic          x_q, x_d;
    logic          x_valid_q, x_valid_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;
    logic          sh_load, sh_shift, sh_msb;
`ifdef SEQ_FRAME_TX_PARITY_EN
    logic          sh_parity;
`endif

    seq_tx_shifter #(.DATA_W(DATA_W)) u_shifter (
        .clk    (clk),
        .reset  (reset),
        .load   (sh_load),
        .shift  (sh_shift),
        .din    (in_data),
        .msb    (sh_msb)
`ifdef SEQ_FRAME_TX_PARITY_EN
        ,
        .parity (sh_parity)
`endif
    );

    // The 4-bit gap counter also times the marker, since the bit counter may be only 1 bit wide.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        sh_load   = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d   = MARK;
                    gap_cnt_d = 4'(SEQ_MARKER_LEN);
                    sh_load   = 1'b1;
                end
            end
            MARK: begin
                if (gap_cnt_q == 4'd1) begin
                    state_d   = DATA;
                    bit_cnt_d = BW'(DATA_W);
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            DATA: begin
                if (bit_cnt_q == BW'(1)) begin
`ifdef SEQ_FRAME_TX_PARITY_EN
                    state_d   = PAR;
`else
                    state_d   = GAP;
                    gap_cnt_d = 4'(GAP_CYCLES);
`endif
                end else begin
                    bit_cnt_d = bit_cnt_q - BW'(1);
                end
            end
`ifdef SEQ_FRAME_TX_PARITY_EN
            PAR: begin
                state_d   = GAP;
                gap_cnt_d = 4'(GAP_CYCLES);
            end
`endif
            GAP: begin
                if (gap_cnt_q == 4'd1) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each bit lands in the cycle its state occupies.
    always_comb begin
        x_d          = 1'b0;
        x_valid_d    = 1'b0;
        frame_done_d = 1'b0;
        busy_d       = (state_d != IDLE);
        sh_shift     = (state_d == DATA);
        case (state_d)
            MARK: begin
                x_valid_d = 1'b1;
                x_d       = SEQ_MARKER[2'(gap_cnt_d - 4'd1)];
            end
            DATA: begin
                x_valid_d = 1'b1;
                x_d       = sh_msb;
`ifndef SEQ_FRAME_TX_PARITY_EN
                frame_done_d = (bit_cnt_d == BW'(1));
`endif
            end
`ifdef SEQ_FRAME_TX_PARITY_EN
            PAR: begin
                x_valid_d    = 1'b1;
                x_d          = sh_parity;
                frame_done_d = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            x_q          <= 1'b0;
            x_valid_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            x_q          <= x_d;
            x_valid_q    <= x_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign in_ready   = (state_q == IDLE) && !reset;
    assign x          = x_q;
    assign x_valid    = x_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed bench for seq_frame_tx: serial bits scored against a queue filled at acceptance time,
// control timing checked cycle by cycle for DATA_W=8/GAP=2 and DATA_W=1/GAP=1 instances.
module tb_seq_frame_tx;

`ifdef SEQ_FRAME_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    always #5 clk = ~clk;

    logic [7:0] in_data;
    logic       in_valid, in_ready, x, x_valid, busy, frame_done;
    logic [0:0] in_data1;
    logic       in_valid1, in_ready1, x1, x_valid1, busy1, frame_done1;

    seq_frame_tx #(.DATA_W(8), .GAP_CYCLES(2)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .x_valid    (x_valid),
        .busy       (busy),
        .frame_done (frame_done)
    );

    seq_frame_tx #(.DATA_W(1), .GAP_CYCLES(1)) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data1),
        .in_valid   (in_valid1),
        .in_ready   (in_ready1),
        .x          (x1),
        .x_valid    (x_valid1),
        .busy       (busy1),
        .frame_done (frame_done1)
    );

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   fd_cnt    = 0;
    logic exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Expected line content of one frame for the 8-bit instance.
    task automatic push_frame(input logic [7:0] w);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        for (int i = 7; i >= 0; i--) exp_q.push_back(w[i]);
        if (P == 1) exp_q.push_back(^w);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (frame_done) fd_cnt++;
            if (x_valid) begin
                if (exp_q.size() == 0) chk("sb_unexpected_bit", 32'(x_valid), 32'd0);
                else chk("sb_x_bit", 32'(x), 32'(exp_q.pop_front()));
            end else begin
                chk("x_low_when_invalid", 32'(x), 32'd0);
            end
        end
    end

    // Samples land just after the falling edge, after the monitor has run.
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!in_ready && n < 60) begin
            cyc();
            n++;
        end
        chk(tag, 32'(in_ready), 32'd1);
    endtask

    task automatic send(input logic [7:0] w);
        wait_ready("send_ready");
        in_data  = w;
        in_valid = 1'b1;
        push_frame(w);
        cyc();
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, fd_save, first_rdy, start2;
        logic prev_xv;
        logic [4:0] bits1;

        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_valid1 = 1'b0; in_data1 = '0;
        cyc(); cyc(); cyc();
        chk("reset_outputs", 32'({in_ready, x, x_valid, busy, frame_done}), 32'd0);
        chk("reset_outputs1", 32'({in_ready1, x1, x_valid1, busy1, frame_done1}), 32'd0);
        reset = 1'b0;
        cyc();
        chk("ready_after_reset", 32'(in_ready), 32'd1);

        // A5 frame: control timeline; in_data changes after acceptance must not matter.
        in_data = 8'hA5; in_valid = 1'b1; push_frame(8'hA5);
        cyc();
        in_valid = 1'b0; in_data = 8'h00;
        for (c = 1; c <= 14 + P; c++) begin
            if (c > 1) cyc();
            chk($sformatf("a5_ctl_c%0d", c), 32'({x_valid, busy, frame_done, in_ready}),
                32'({c <= 11 + P, c <= 13 + P, c == 11 + P, c == 14 + P}));
        end
        chk("a5_fd_count", 32'(fd_cnt), 32'd1);

        // 07: odd weight, parity bit 1 when enabled.
        send(8'h07);
        wait_ready("h07_done");
        chk("h07_fd_count", 32'(fd_cnt), 32'd2);

        // Back-to-back with in_valid held high.
        in_data = 8'hFF; in_valid = 1'b1;
        push_frame(8'hFF); push_frame(8'h00);
        cyc();
        in_data = 8'h00;
        prev_xv = 1'b1; first_rdy = 0; start2 = 0;
        for (c = 2; c <= 40; c++) begin
            cyc();
            if (in_ready && first_rdy == 0) first_rdy = c;
            if (x_valid && !prev_xv) begin
                start2 = c;
                break;
            end
            prev_xv = x_valid;
        end
        in_valid = 1'b0;
        chk("b2b_first_ready_cycle", 32'(first_rdy), 32'(14 + P));
        chk("b2b_second_marker_cycle", 32'(start2), 32'(15 + P));
        chk("b2b_period", 32'(start2 - 1), 32'(14 + P));
        wait_ready("b2b_done");
        chk("b2b_fd_count", 32'(fd_cnt), 32'd4);

        // in_valid pulse with 3C during DATA must be ignored.
        send(8'h5A);
        for (c = 2; c <= 6; c++) cyc();
        in_data = 8'h3C; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        first_rdy = 0;
        for (c = 8; c <= 40; c++) begin
            cyc();
            if (in_ready) begin
                first_rdy = c;
                break;
            end
        end
        chk("ign_ready_cycle", 32'(first_rdy), 32'(14 + P));
        cyc(); cyc(); cyc();
        chk("ign_no_second_frame", 32'({busy, x_valid}), 32'd0);
        chk("ign_fd_count", 32'(fd_cnt), 32'd5);

        // Reset asserted in cycle 6 of a frame.
        send(8'h96);
        for (c = 2; c <= 6; c++) cyc();
        fd_save = fd_cnt;
        #1 reset = 1'b1;
        #1 chk("rst_mid_outputs", 32'({x, x_valid, busy, in_ready, frame_done}), 32'd0);
        exp_q.delete();
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        chk("rst_release_ready", 32'(in_ready), 32'd1);
        chk("rst_no_frame_done", 32'(fd_cnt), 32'(fd_save));
        send(8'hC3);
        wait_ready("rst_next_done");
        chk("rst_next_fd_count", 32'(fd_cnt), 32'(fd_save + 1));

        // DATA_W=1, GAP_CYCLES=1, payload 0.
        bits1 = 5'b10100;
        chk("w1_ready", 32'(in_ready1), 32'd1);
        in_data1 = 1'b0; in_valid1 = 1'b1;
        cyc();
        in_valid1 = 1'b0;
        for (c = 1; c <= 6 + P; c++) begin
            if (c > 1) cyc();
            chk($sformatf("w1_c%0d", c), 32'({x1, x_valid1, busy1, frame_done1, in_ready1}),
                32'({(c <= 4 + P) ? bits1[5 - c] : 1'b0, c <= 4 + P, c <= 5 + P, c == 4 + P, c == 6 + P}));
        end

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/seq_frame_tx.md
# seq_frame_tx

Serial frame transmitter that drives the single-bit line consumed by the team's "101" sequence detectors. It accepts a parallel word over a valid/ready handshake and emits a fixed `101` marker, then the word MSB-first. It then holds the line low for a programmable idle gap. It sits upstream of the detector chain and acts as the stimulus and link source for serial-pattern tests.

## Interface
- `DATA_W`, default 8: payload width in bits. Legal range 1..32.
- `GAP_CYCLES`, default 2: idle-low cycles after each frame. Legal range 1..15.
- `clk`, input, 1: clock. All state changes on the rising edge.
- `reset`, input, 1: reset, asynchronous, active-high.
- `in_data`, input, DATA_W: payload word. Sampled only on the acceptance edge.
- `in_valid`, input, 1: payload offered.
- `in_ready`, output, 1: block can accept. High only in IDLE and while `reset` is low.
- `x`, output, 1: serial line. Registered.
- `x_valid`, output, 1: high while `x` carries a marker, data or parity bit. Registered.
- `busy`, output, 1: high from the cycle after acceptance until the return to IDLE. Registered.
- `frame_done`, output, 1: one-cycle pulse during the last bit of the frame. Registered.

## Operation
- FSM states: IDLE, MARK, DATA, PAR (present only with the macro), GAP.
- IDLE: `x=0`, `x_valid=0`. A handshake occurs when `in_valid && in_ready` at a rising edge. On a handshake the block captures `in_data` into the shift register and moves to MARK.
- MARK: 3 cycles, driving `x`=1, 0, 1 in that order, with `x_valid=1`. Then moves to DATA.
- DATA: DATA_W cycles, MSB first, with `x_valid=1`. Then moves to PAR if compiled in, otherwise to GAP.
- PAR: 1 cycle carrying the parity bit, with `x_valid=1`. Then moves to GAP.
- GAP: GAP_CYCLES cycles with `x=0` and `x_valid=0`. Then moves to IDLE.
- `x` is 0 whenever `x_valid` is 0.
- Counters:
  - bit counter, $clog2(DATA_W+1) bits;
  - gap counter, 4 bits.
  - Both counters load on state entry and count down; the state exits when the counter reaches 1. Neither counter wraps.
- `in_valid` is ignored while not in IDLE. The captured word is unaffected by `in_data` changes after acceptance.
- Payload contents are not stuffed. A `101` pattern inside the data is legal and is passed through unchanged.
- Reset values: state IDLE, `x=0`, `x_valid=0`, `busy=0`, `frame_done=0`, `in_ready=0` while reset is asserted. The shift register clears to 0.
- Reset mid-frame: outputs go to their reset values immediately. The frame is aborted, no `frame_done` pulse is issued, and the word is discarded.

## Timing
- Acceptance edge is cycle 0. The first marker bit appears on `x` in cycle 1.
- Marker occupies cycles 1–3. Data occupies cycles 4..3+DATA_W. Parity, if enabled, occupies cycle 4+DATA_W.
- `frame_done` is high in the cycle of the last data or parity bit.
- `in_ready` rises in cycle 4+DATA_W+P+GAP_CYCLES, where P=1 with parity and P=0 without.
- Back-to-back frames: with `in_valid` held high, the next acceptance occurs in that first in_ready cycle. Frame period is 3+DATA_W+P+GAP_CYCLES+1 cycles.
- No combinational path from inputs to `x`, `x_valid` or `busy`. `in_ready` is decoded from the registered state only.

## Configuration
- `SEQ_FRAME_TX_PARITY_EN` defined: the PAR state is compiled in. It emits even parity, so the total count of ones over data plus parity is even. `frame_done` moves to the parity cycle.
- Macro undefined: the PAR state and parity logic are absent. The frame ends on the last data bit.

## Structure
- Shared package `seq_pkg` holds:
  - state enum typedef `seq_tx_state_t`;
  - constant `SEQ_MARKER = 3'b101`;
  - constant `SEQ_MARKER_LEN = 3`.
- The detector side reuses the same `SEQ_MARKER` constant.
- One sub-module, `seq_tx_shifter`: DATA_W parallel-load, MSB-first shift register with load and shift enables, `msb` output and running parity.

## Test plan
- DATA_W=8, GAP_CYCLES=2, no parity, `in_data=8'hA5`:
  - `x` over cycles 1–11 = 1,0,1,1,0,1,0,0,1,0,1;
  - `frame_done` in cycle 11;
  - `x=0`, `x_valid=0` in cycles 12–13;
  - `in_ready=1` in cycle 14.
- Parity enabled:
  - `8'hA5` gives parity bit 0 in cycle 12 with `frame_done` in cycle 12.
  - `8'h07` gives parity bit 1.
- `in_valid` held high with words `8'hFF` then `8'h00`:
  - second marker starts exactly one cycle after the first `in_ready` rise;
  - period is 14 cycles.
- `in_valid` pulsed with `8'h3C` during DATA of a prior frame: the pulse is ignored, and no second frame or `busy` extension occurs.
- Reset asserted in cycle 6 of a frame:
  - `x`, `x_valid`, `busy` go to 0 in the same cycle;
  - no `frame_done` pulse;
  - after release, `in_ready=1` and the next frame is transmitted intact.
- DATA_W=1, GAP_CYCLES=1, `in_data=1'b0`:
  - `x` = 1,0,1,0;
  - `frame_done` in cycle 4;
  - `in_ready` in cycle 6.
